// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle ADD/SUB/logic ops, multi-cycle shift-add MUL and restoring DIV.
// Define ALU_MULDIV_EN to build the MUL/DIV datapath; without it those opcodes just flag err.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  // Ripple chain of full-adder cells; returns {carry_out, sum}.
  function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             cin);
    logic             c;
    logic [WIDTH-1:0] s;
    c = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] single_hi;
  logic             single_carry;
  logic             single_err;
  logic             accept_single;

  assign add_sum = ripple_add(a, b, 1'b0);
  assign sub_sum = ripple_add(a, ~b, 1'b1);

  always_comb begin
    single_res   = '0;
    single_hi    = '0;
    single_carry = 1'b0;
    single_err   = 1'b0;
    case (op)
      OP_ADD: begin
        single_res   = add_sum[WIDTH-1:0];
        single_carry = add_sum[WIDTH];
      end
      OP_SUB: begin
        // a + ~b + 1 carries out exactly when no borrow occurred
        single_res   = sub_sum[WIDTH-1:0];
        single_carry = ~sub_sum[WIDTH];
      end
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_XOR:  single_res = a ^ b;
      OP_NOT:  single_res = ~a;
      default: begin
`ifdef ALU_MULDIV_EN
        if (op == OP_DIV) begin
          single_res = '1;
          single_hi  = a;
          single_err = 1'b1;
        end
`else
        single_err = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             accept_multi;
  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  assign busy          = (state == RUN);
  assign accept_multi  = start && !busy && ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));
  assign accept_single = start && !busy && !accept_multi;
  assign last_iter     = busy && (cnt == CNT_W'(1));

  // {hi,lo} is the shared MUL product / DIV remainder:quotient register pair
  assign mul_sum   = lo[0] ? ripple_add(hi, opnd, 1'b0) : {1'b0, hi};
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd};

  always_comb begin
    next_hi = mul_sum[WIDTH:1];
    next_lo = {mul_sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      next_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      next_lo = {lo[WIDTH-2:0], ~div_trial[WIDTH]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept_multi) begin
      state <= RUN;
      cnt   <= CNT_W'(WIDTH);
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (last_iter) state <= IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_multi) begin
      hi     <= '0;
      lo     <= a;
      opnd   <= b;
      is_div <= (op == OP_DIV);
    end else if (busy) begin
      hi <= next_hi;
      lo <= next_lo;
    end
  end
`else
  assign busy          = 1'b0;
  assign accept_single = start;
`endif

  // Output registers: loaded on single-cycle accept or on the final MUL/DIV iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_single) begin
        result    <= single_res;
        result_hi <= single_hi;
        carry     <= single_carry;
        err       <= single_err;
        zero      <= (single_res == '0);
        done      <= 1'b1;
      end
`ifdef ALU_MULDIV_EN
      else if (last_iter) begin
        result    <= next_lo;
        result_hi <= next_hi;
        carry     <= 1'b0;
        err       <= 1'b0;
        zero      <= (next_lo == '0);
        done      <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq against an arithmetic reference model; honours ALU_MULDIV_EN.
module tb_alu_seq;
  localparam int W = 16;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .carry(carry), .zero(zero), .err(err)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         e;
    logic [7:0]   lat;
    logic [7:0]   bcnt;
  } obs_t;

  function automatic obs_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    obs_t m;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    m     = '0;
    m.lat = 8'd1;
    case (o)
      3'd0: begin s = {1'b0, x} + {1'b0, y}; m.res = s[W-1:0]; m.c = s[W]; end
      3'd1: begin m.res = x - y; m.c = (x < y); end
      3'd2: m.res = x & y;
      3'd3: m.res = x | y;
      3'd4: m.res = x ^ y;
      3'd5: m.res = ~x;
      3'd6: begin
        if (MD) begin
          p      = (2*W)'(x) * (2*W)'(y);
          m.res  = p[W-1:0];
          m.hi   = p[2*W-1:W];
          m.lat  = 8'(W);
          m.bcnt = 8'(W);
        end else m.e = 1'b1;
      end
      default: begin
        if (!MD) m.e = 1'b1;
        else if (y == 0) begin m.res = '1; m.hi = x; m.e = 1'b1; end
        else begin
          m.res  = x / y;
          m.hi   = x % y;
          m.lat  = 8'(W);
          m.bcnt = 8'(W);
        end
      end
    endcase
    m.z = (m.res == 0);
    return m;
  endfunction

  // Issue one op, then observe until done; poke>0 pulses an ADD start at that sample while running.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int poke, output obs_t r);
    int n;
    r = '0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    n = 1;
    forever begin
      if (busy) r.bcnt = r.bcnt + 8'd1;
      if (done || n >= 64) break;
      if (n == poke) begin
        @(negedge clk);
        start = 1'b1; op = 3'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    r.lat = 8'(n);
    r.res = result; r.hi = result_hi; r.c = carry; r.z = zero; r.e = err;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, result_hi, carry, zero, err} !== '0)
      $display("FAIL reset: got busy=%b done=%b res=%h hi=%h c=%b z=%b e=%b, expected all 0",
               busy, done, result, result_hi, carry, zero, err);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_logic_ops;
    logic [2:0]   ops[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [W-1:0] as[6]  = '{16'd756, 16'd5, 16'h00F0, 16'h00F0, 16'h00F0, 16'h0000};
    logic [W-1:0] bs[6]  = '{16'd3080, 16'd7, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h1234};
    obs_t r, e;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], 0, r);
      e = model(ops[i], as[i], bs[i]);
      checks++;
      if (r !== e)
        $display("FAIL logic_op[%0d]: got res=%h hi=%h c=%b z=%b e=%b lat=%0d busy=%0d, expected res=%h hi=%h c=%b z=%b e=%b lat=%0d busy=%0d",
                 i, r.res, r.hi, r.c, r.z, r.e, r.lat, r.bcnt, e.res, e.hi, e.c, e.z, e.e, e.lat, e.bcnt);
      else passes++;
    end
    issue(3'd0, 16'hFFFF, 16'h0001, 0, r);
    checks++;
    if ({r.res, r.c, r.z} !== {16'h0000, 1'b1, 1'b1})
      $display("FAIL add_wrap: got res=%h c=%b z=%b, expected res=0000 c=1 z=1", r.res, r.c, r.z);
    else passes++;
  endtask

  task automatic test_mul;
    obs_t r, e;
    issue(3'd6, 16'd300, 16'd300, 8, r);
    e = model(3'd6, 16'd300, 16'd300);
    checks++;
    if (r !== e)
      $display("FAIL mul_300x300: got res=%h hi=%h e=%b lat=%0d busy=%0d, expected res=%h hi=%h e=%b lat=%0d busy=%0d",
               r.res, r.hi, r.e, r.lat, r.bcnt, e.res, e.hi, e.e, e.lat, e.bcnt);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) $display("FAIL mul_no_queued_op: got done=%b, expected 0", done);
    else passes++;
    issue(3'd6, 16'd3, 16'd4, 0, r);
    e = model(3'd6, 16'd3, 16'd4);
    checks++;
    if (r !== e)
      $display("FAIL mul_3x4: got res=%h hi=%h e=%b lat=%0d busy=%0d, expected res=%h hi=%h e=%b lat=%0d busy=%0d",
               r.res, r.hi, r.e, r.lat, r.bcnt, e.res, e.hi, e.e, e.lat, e.bcnt);
    else passes++;
  endtask

  task automatic test_div;
    logic [W-1:0] as[3] = '{16'd1000, 16'd9, 16'd5};
    logic [W-1:0] bs[3] = '{16'd7, 16'd0, 16'd9};
    obs_t r, e;
    for (int i = 0; i < 3; i++) begin
      issue(3'd7, as[i], bs[i], 0, r);
      e = model(3'd7, as[i], bs[i]);
      checks++;
      if (r !== e)
        $display("FAIL div[%0d]: got res=%h hi=%h z=%b e=%b lat=%0d busy=%0d, expected res=%h hi=%h z=%b e=%b lat=%0d busy=%0d",
                 i, r.res, r.hi, r.z, r.e, r.lat, r.bcnt, e.res, e.hi, e.z, e.e, e.lat, e.bcnt);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_run;
    obs_t r, e;
    bit   saw_done;
    issue(3'd5, 16'h0000, 16'h0000, 0, r);
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 16'd300; b = 16'd300;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, result, result_hi, carry, zero, err} !== '0)
      $display("FAIL reset_mid_run: got busy=%b done=%b res=%h hi=%h c=%b z=%b e=%b, expected all 0",
               busy, done, result, result_hi, carry, zero, err);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) $display("FAIL aborted_done: got done seen=%b, expected 0", saw_done);
    else passes++;
    issue(3'd0, 16'd1, 16'd1, 0, r);
    e = model(3'd0, 16'd1, 16'd1);
    checks++;
    if (r !== e)
      $display("FAIL add_after_reset: got res=%h c=%b lat=%0d, expected res=%h c=%b lat=%0d",
               r.res, r.c, r.lat, e.res, e.c, e.lat);
    else passes++;
  endtask

  task automatic test_back_to_back;
    obs_t         r, e;
    logic [2:0]   o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      if (o == 3'd6 && y == 0) y = 16'd1;
      if (o == 3'd7 && $urandom_range(0, 5) == 0) y = '0;
      if (o == 3'd7 && $urandom_range(0, 3) == 0) y = W'($urandom_range(1, 15));
      issue(o, x, y, 0, r);
      e = model(o, x, y);
      checks++;
      if (r !== e)
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h hi=%h c=%b z=%b e=%b lat=%0d busy=%0d, expected res=%h hi=%h c=%b z=%b e=%b lat=%0d busy=%0d",
                 i, o, x, y, r.res, r.hi, r.c, r.z, r.e, r.lat, r.bcnt, e.res, e.hi, e.c, e.z, e.e, e.lat, e.bcnt);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_logic_ops();
    test_mul();
    test_div();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
